keccak_perm_arbiter: RTL and testbench
======================================

Name: keccak_perm_arbiter

Overview:
Round-robin arbiter and sequencer that shares one Keccak-p[1600] permutation core (controller plus round datapath) among NUM_REQ hash lanes. It selects a requester, drives the core's start, round count and input-select, waits for the core's done, and returns a per-lane completion or error pulse. A watchdog recovers the core if done never arrives.

Parameters:
NUM_REQ, 4, number of requesting lanes (2..8)
SEL_W, $clog2(NUM_REQ), width of the core input-mux select
TIMEOUT, 32, maximum WAIT cycles before recovery (must exceed 24 + core overhead)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_req  in  NUM_REQ  per-lane request; level, held until o_done or o_err for that lane
i_num_rounds  in  5*NUM_REQ  packed per-lane round count, lane k at [5k+4:5k]
o_grant  out  NUM_REQ  one-hot, active lane
o_done  out  NUM_REQ  one-cycle completion pulse to the granted lane
o_err  out  NUM_REQ  one-cycle error pulse (bad round count or timeout)
o_busy  out  1  high in every state except IDLE
o_core_start  out  1  one-cycle start pulse to the permutation core
o_core_num_rounds  out  5  round count of the granted lane, stable from START to RELEASE
o_core_sel  out  SEL_W  index of the granted lane; drives the core's state input/output mux
o_core_rst  out  1  one-cycle synchronous reset to the core, asserted only in RECOVER
i_core_done  in  1  core completion pulse

Behaviour:
- Reset (async assert, sync deassert at the top level): state=IDLE, rr pointer=0. All outputs 0, including o_grant, o_done, o_err, o_busy, o_core_start, o_core_num_rounds, o_core_sel and o_core_rst. A reset mid-operation aborts with no o_done or o_err pulse.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, RELEASE, RECOVER.
- IDLE:
  - Choose the first lane with i_req=1, searching from the rr pointer upward modulo NUM_REQ.
  - If its round count is 1..24: latch its index and round count, then go to START.
  - If its round count is 0 or >24: pulse o_err[k] for one cycle, advance rr to k+1, and stay in IDLE. The core is never started.
  - If no request: stay in IDLE.
- START (1 cycle): o_grant, o_core_sel and o_core_num_rounds are valid; o_core_start=1. Next state is WAIT.
- WAIT:
  - Watchdog counter starts at 0 and increments each cycle.
  - On i_core_done=1, go to RELEASE.
  - When the counter reaches TIMEOUT-1 with no done, go to RECOVER.
  - If done and timeout occur in the same cycle, done wins.
- RELEASE (1 cycle): o_done[k]=1, rr=k+1 (wraps to 0 after NUM_REQ-1). o_grant clears on exit. Next state is IDLE.
- RECOVER (1 cycle): o_core_rst=1, o_err[k]=1, rr=k+1. Next state is IDLE.
- Latency: request sampled in IDLE at cycle t gives grant and core_start at t+1. o_done comes one cycle after i_core_done.
- Back-to-back: the next grant's START is at least 2 cycles after RELEASE (RELEASE → IDLE → START).
- i_req dropped mid-operation: the operation still completes and o_done still pulses; the lane ignores it.
- i_core_done outside WAIT is ignored.
- Starvation bound: a continuously requesting lane is granted within NUM_REQ-1 other operations.
- i_num_rounds changing after the latch has no effect on the current operation.

Decomposition:
- Shared package keccak_pkg holds: KECCAK_MAX_ROUNDS=24, the round-count width 5, and the FSM state encoding localparams (IDLE, START, WAIT, RELEASE, RECOVER).
- One natural sub-module, rr_priority_pick: combinational rotate, priority-encode and unrotate. Inputs are req and pointer; outputs are a one-hot grant and an index. It is reusable by other shared-resource arbiters.

Test Plan:
- Single lane: i_req=0001, rounds=24, core model returns done 25 cycles after start → o_core_start pulses at t+1, o_core_sel=0, o_done=0001 one cycle after done, o_busy low afterwards.
- Fairness: all four lanes request continuously, rounds=12 → grants in order 0,1,2,3,0; each lane receives exactly one o_done per four operations.
- Bad rounds: lane 2 requests with rounds=0, then with rounds=25 → o_err=0100 each time; o_core_start never pulses; rr moves to 3.
- Timeout: core model never asserts done, TIMEOUT=32 → after 32 WAIT cycles o_core_rst=1 and o_err of the granted lane pulse together; FSM back in IDLE the next cycle.
- Done coincident with the last timeout cycle → RELEASE taken: o_done pulses, o_core_rst stays 0.
- Async reset asserted during WAIT → all outputs 0 immediately with no clock edge; after release, a fresh request is granted starting from lane 0.

Source files
------------

// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared constants and types for the Keccak-p[1600] permutation sharing logic:
// the maximum round count, the round-count field width, the sequencer state
// encoding and a round-count validity helper.
// -----------------------------------------------------------------------------
package keccak_pkg;

  localparam int unsigned KECCAK_MAX_ROUNDS = 24;
  localparam int unsigned ROUND_W           = 5;
  localparam int unsigned STATE_W           = 3;

  // Sequencer states of the permutation arbiter
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RECOVER = 3'd4
  } arb_state_e;

  // A round count is usable by the core only when it lies in 1..24
  function automatic logic rounds_ok(input logic [ROUND_W-1:0] rounds);
    return (rounds != '0) && (rounds <= ROUND_W'(KECCAK_MAX_ROUNDS));
  endfunction

endpackage

// File: rtl/keccak_perm_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin pick: finds the first asserted request at or above
// the pointer, wrapping modulo NUM_REQ.
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < NUM_REQ)
//   grant_o : one-hot winner, all zeros when nothing requests
//   idx_o   : index of the winner, 0 when nothing requests
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic             found;
  logic [SEL_W-1:0] cand;
  int unsigned      pos;

  // Walk the requests in priority order starting at the pointer
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      cand = SEL_W'(pos);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    grant_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/keccak_perm_arbiter.sv
// -----------------------------------------------------------------------------
// keccak_perm_arbiter
// Round-robin arbiter/sequencer sharing one Keccak-p[1600] permutation core
// among NUM_REQ lanes, with a watchdog that resets a core that never finishes.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_req                : per-lane request level
//   i_num_rounds         : packed per-lane round counts, lane k at [5k+4:5k]
//   o_grant              : one-hot active lane
//   o_done / o_err       : per-lane completion / error pulses
//   o_busy               : sequencer not idle
//   o_core_start         : start pulse to the core
//   o_core_num_rounds    : latched round count of the granted lane
//   o_core_sel           : granted lane index (core state mux select)
//   o_core_rst           : recovery reset pulse to the core
//   i_core_done          : core completion pulse
// All outputs are registered and describe the state entered at each edge.
// -----------------------------------------------------------------------------
module keccak_perm_arbiter
  import keccak_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SEL_W   = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [ROUND_W*NUM_REQ-1:0] i_num_rounds,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NUM_REQ-1:0]         o_done,
  output logic [NUM_REQ-1:0]         o_err,
  output logic                       o_busy,
  output logic                       o_core_start,
  output logic [ROUND_W-1:0]         o_core_num_rounds,
  output logic [SEL_W-1:0]           o_core_sel,
  output logic                       o_core_rst,
  input  logic                       i_core_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [SEL_W-1:0]   lane_q, lane_d;
  logic [ROUND_W-1:0] rounds_q, rounds_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [ROUND_W-1:0] core_rounds_q, core_rounds_d;
  logic [SEL_W-1:0]   core_sel_q, core_sel_d;
  logic               core_rst_q, core_rst_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [SEL_W-1:0]   pick_idx;
  logic [ROUND_W-1:0] pick_rounds;
  logic [NUM_REQ-1:0] lane_oh;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req_i   (i_req),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Round count of the candidate lane
  always_comb begin
    pick_rounds = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == SEL_W'(k)) begin
        pick_rounds = i_num_rounds[k*ROUND_W +: ROUND_W];
      end
    end
  end

  // Pointer advance with wrap for non power-of-two lane counts
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(NUM_REQ - 1)) ? '0 : idx + SEL_W'(1);
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    lane_d        = lane_q;
    rounds_d      = rounds_q;
    cnt_d         = cnt_q;
    grant_d       = '0;
    done_d        = '0;
    err_d         = '0;
    start_d       = 1'b0;
    core_rst_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          if (rounds_ok(pick_rounds)) begin
            lane_d   = pick_idx;
            rounds_d = pick_rounds;
            state_d  = ST_START;
          end else begin
            // Unusable round count: reject without touching the core
            err_d = pick_grant;
            rr_d  = next_ptr(pick_idx);
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done has priority over an expiring watchdog
        if (i_core_done) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    lane_oh = NUM_REQ'(1) << lane_d;

    case (state_d)
      ST_START: begin
        grant_d = lane_oh;
        start_d = 1'b1;
      end
      ST_WAIT: grant_d = lane_oh;
      ST_RELEASE: begin
        grant_d = lane_oh;
        done_d  = lane_oh;
        rr_d    = next_ptr(lane_q);
      end
      ST_RECOVER: begin
        grant_d    = lane_oh;
        err_d      = lane_oh;
        core_rst_d = 1'b1;
        rr_d       = next_ptr(lane_q);
      end
      default: ;
    endcase

    busy_d        = (state_d != ST_IDLE);
    core_sel_d    = busy_d ? lane_d : '0;
    core_rounds_d = busy_d ? rounds_d : '0;
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      rr_q          <= '0;
      lane_q        <= '0;
      rounds_q      <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      err_q         <= '0;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      core_rounds_q <= '0;
      core_sel_q    <= '0;
      core_rst_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      lane_q        <= lane_d;
      rounds_q      <= rounds_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      start_q       <= start_d;
      core_rounds_q <= core_rounds_d;
      core_sel_q    <= core_sel_d;
      core_rst_q    <= core_rst_d;
    end
  end

  assign o_grant           = grant_q;
  assign o_done            = done_q;
  assign o_err             = err_q;
  assign o_busy            = busy_q;
  assign o_core_start      = start_q;
  assign o_core_num_rounds = core_rounds_q;
  assign o_core_sel        = core_sel_q;
  assign o_core_rst        = core_rst_q;

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_keccak_perm_arbiter
// Self-checking bench: a transaction-level model of the arbiter predicts every
// output after each clock edge; directed scenarios pin latencies and ordering
// with literal values, followed by a randomized run with a simple core model.
// -----------------------------------------------------------------------------
module tb_keccak_perm_arbiter;

  localparam int N  = 4;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [5*N-1:0] nr;
  logic           core_done;

  logic [N-1:0]   o_grant, o_done, o_err;
  logic           o_busy, o_core_start, o_core_rst;
  logic [4:0]     o_core_num_rounds;
  logic [1:0]     o_core_sel;

  keccak_perm_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_req             (req),
    .i_num_rounds      (nr),
    .o_grant           (o_grant),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_busy            (o_busy),
    .o_core_start      (o_core_start),
    .o_core_num_rounds (o_core_num_rounds),
    .o_core_sel        (o_core_sel),
    .o_core_rst        (o_core_rst),
    .i_core_done       (core_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: one operation record plus round-robin pointer
  int m_busy, m_lane, m_rounds, m_age, m_end, m_rr;
  logic [N-1:0] e_grant, e_done, e_err;
  logic         e_busy, e_start, e_crst;

  int cd = 0;
  int core_lat = 0;
  bit auto_drop = 1'b1;
  bit spur_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_nr(input int k, input int v);
    nr[k*5 +: 5] = 5'(v);
  endtask

  function automatic int rand_rounds();
    int x;
    x = int'($urandom_range(0, 19));
    if (x < 17) return int'($urandom_range(1, 24));
    if (x == 17) return 0;
    return int'($urandom_range(25, 31));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_lane = 0; m_rounds = 0; m_age = 0; m_end = 0; m_rr = 0;
    e_grant = '0; e_done = '0; e_err = '0;
    e_busy = 1'b0; e_start = 1'b0; e_crst = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_edge();
    int k, r;
    bit found;
    e_done = '0; e_err = '0; e_start = 1'b0; e_crst = 1'b0;
    if (m_end != 0) begin
      m_busy = 0;
      m_end  = 0;
    end else if (m_busy == 0) begin
      found = 1'b0;
      k = 0;
      for (int s = 0; s < N; s++) begin
        if (!found && req[(m_rr + s) % N]) begin
          found = 1'b1;
          k = (m_rr + s) % N;
        end
      end
      if (found) begin
        r = int'(nr[k*5 +: 5]);
        if (r >= 1 && r <= 24) begin
          m_busy = 1; m_lane = k; m_rounds = r; m_age = 0;
          e_start = 1'b1;
        end else begin
          e_err[k] = 1'b1;
          m_rr = (k + 1) % N;
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else begin
      // m_age-1 cycles of WAIT have elapsed before this edge
      if (core_done) begin
        m_end = 1;
        e_done[m_lane] = 1'b1;
        m_rr = (m_lane + 1) % N;
      end else if (m_age - 1 == TO - 1) begin
        m_end = 2;
        e_err[m_lane] = 1'b1;
        e_crst = 1'b1;
        m_rr = (m_lane + 1) % N;
      end else begin
        m_age++;
      end
    end
    e_busy  = (m_busy != 0);
    e_grant = e_busy ? (N'(1) << m_lane) : '0;
  endtask

  task automatic compare();
    chk("grant", 32'(o_grant), 32'(e_grant));
    chk("done", 32'(o_done), 32'(e_done));
    chk("err", 32'(o_err), 32'(e_err));
    chk("busy", 32'(o_busy), 32'(e_busy));
    chk("core_start", 32'(o_core_start), 32'(e_start));
    chk("core_rst", 32'(o_core_rst), 32'(e_crst));
    if (e_busy) begin
      chk("core_sel", 32'(o_core_sel), 32'(m_lane));
      chk("core_rounds", 32'(o_core_num_rounds), 32'(m_rounds));
    end
  endtask

  // One clock: model update at the edge, compare after it, then drive lanes/core
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare();
    if (auto_drop) req = req & ~(e_done | e_err);
    if (e_start) cd = core_lat;
    if (e_crst || !rst_n) cd = 0;
    core_done = (cd == 1);
    if (spur_en && !(m_busy != 0 && m_age >= 1 && m_end == 0) && $urandom_range(0, 9) == 0)
      core_done = 1'b1;
    if (cd > 0) cd--;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((o_busy || req != '0) && n < lim) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(o_busy), 32'(0));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_grant"}, 32'(o_grant), 0);
    chk({nm, "_done"}, 32'(o_done), 0);
    chk({nm, "_err"}, 32'(o_err), 0);
    chk({nm, "_busy"}, 32'(o_busy), 0);
    chk({nm, "_start"}, 32'(o_core_start), 0);
    chk({nm, "_rounds"}, 32'(o_core_num_rounds), 0);
    chk({nm, "_sel"}, 32'(o_core_sel), 0);
    chk({nm, "_crst"}, 32'(o_core_rst), 0);
  endtask

  initial begin
    int n, starts, dones, gi;
    int order[8];
    int dcnt[N];

    rst_n = 1'b1; req = '0; nr = '0; core_done = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Fairness: all lanes request continuously, rr starts at 0
    auto_drop = 1'b0;
    for (int k = 0; k < N; k++) set_nr(k, 12);
    core_lat = 4;
    req = 4'b1111;
    starts = 0; dones = 0; n = 0;
    for (int k = 0; k < N; k++) dcnt[k] = 0;
    while (dones < 8 && n < 300) begin
      step();
      n++;
      if (o_core_start && starts < 8) begin
        gi = 0;
        for (int k = 0; k < N; k++) if (o_grant[k]) gi = k;
        order[starts] = gi;
        starts++;
      end
      for (int k = 0; k < N; k++) if (o_done[k]) begin dcnt[k]++; dones++; end
    end
    for (int i = 0; i < 8; i++) chk("fair_order", 32'(order[i]), 32'(i % 4));
    for (int k = 0; k < N; k++) chk("fair_dones", 32'(dcnt[k]), 32'(2));
    auto_drop = 1'b1;
    req = '0;
    drain(100);

    // Single lane, 24 rounds, core done 25 cycles after start
    set_nr(0, 24);
    core_lat = 25;
    req = 4'b0001;
    step();
    chk("single_start", 32'(o_core_start), 1);
    chk("single_sel", 32'(o_core_sel), 0);
    chk("single_rounds", 32'(o_core_num_rounds), 24);
    n = 0;
    do begin step(); n++; end while (o_done == '0 && n < 60);
    chk("single_done_lat", 32'(n), 25);
    chk("single_done", 32'(o_done), 32'h1);
    step();
    chk("single_idle", 32'(o_busy), 0);

    // Bad round counts on lane 2, then rr must point at lane 3
    set_nr(2, 0);
    req = 4'b0100;
    step();
    chk("bad0_err", 32'(o_err), 32'h4);
    chk("bad0_start", 32'(o_core_start), 0);
    step();
    set_nr(2, 25);
    req = 4'b0100;
    step();
    chk("bad25_err", 32'(o_err), 32'h4);
    chk("bad25_start", 32'(o_core_start), 0);
    step();
    set_nr(0, 5); set_nr(3, 5);
    core_lat = 3;
    req = 4'b1001;
    step();
    chk("bad_rr_grant", 32'(o_grant), 32'h8);
    drain(100);

    // Watchdog: core never finishes
    set_nr(1, 8);
    core_lat = 0;
    req = 4'b0010;
    step();
    n = 0;
    do begin step(); n++; end while (!o_core_rst && o_done == '0 && o_err == '0 && n < 60);
    chk("tmo_lat", 32'(n), 33);
    chk("tmo_crst", 32'(o_core_rst), 1);
    chk("tmo_err", 32'(o_err), 32'h2);
    step();
    chk("tmo_idle", 32'(o_busy), 0);

    // Done coincident with the last watchdog cycle
    set_nr(2, 3);
    core_lat = TO + 1;
    req = 4'b0100;
    step();
    n = 0;
    do begin step(); n++; end while (!o_core_rst && o_done == '0 && o_err == '0 && n < 60);
    chk("coinc_lat", 32'(n), 33);
    chk("coinc_done", 32'(o_done), 32'h4);
    chk("coinc_crst", 32'(o_core_rst), 0);
    step();
    chk("coinc_idle", 32'(o_busy), 0);

    // Async reset in WAIT, then restart from lane 0
    set_nr(3, 20);
    core_lat = 0;
    req = 4'b1000;
    step();
    chk("rst_pre_grant", 32'(o_grant), 32'h8);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    cd = 0; req = '0; core_done = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    set_nr(0, 7); set_nr(3, 7);
    core_lat = 5;
    req = 4'b1001;
    step();
    chk("rst_restart_grant", 32'(o_grant), 32'h1);
    drain(200);

    // Randomized traffic
    spur_en = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 7) == 0) begin
          set_nr(k, rand_rounds());
          req[k] = 1'b1;
        end
      end
      if (m_busy != 0 && $urandom_range(0, 3) == 0) set_nr(m_lane, rand_rounds());
      if (m_busy != 0 && m_end == 0 && $urandom_range(0, 15) == 0) req[m_lane] = 1'b0;
      n = int'($urandom_range(0, 9));
      if (n < 7) core_lat = int'($urandom_range(2, 30));
      else if (n == 7) core_lat = int'($urandom_range(31, 34));
      else core_lat = 0;
      step();
    end
    spur_en = 1'b0;
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
